// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide instruction-memory port between IF fetch (word read) and
// the program loader (word write); words are moved as four big-endian bytes.
module imem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [3:0]        dbg_state_o
);

  if (MEM_BYTES != (1 << ADDR_W)) begin : g_size_check
    $error("imem_port_arbiter: MEM_BYTES must equal 2**ADDR_W");
  end

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] RD0  = 4'd1;
  localparam logic [3:0] RD1  = 4'd2;
  localparam logic [3:0] RD2  = 4'd3;
  localparam logic [3:0] RD3  = 4'd4;
  localparam logic [3:0] RDW  = 4'd5;
  localparam logic [3:0] WR0  = 4'd6;
  localparam logic [3:0] WR1  = 4'd7;
  localparam logic [3:0] WR2  = 4'd8;
  localparam logic [3:0] WR3  = 4'd9;
  localparam logic [3:0] DONE = 4'd10;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_LOAD  = 1'b1;

  logic [3:0]        state_q, state_d;
  logic              last_grant_q;
  logic [ADDR_W-3:0] base_q;
  logic [31:0]       wdata_q;
  logic              op_rd_q;
  logic [23:0]       asm_q;
  logic [31:0]       fetch_instr_q;

  logic              idle;
  logic              grant_fetch;
  logic              grant_load;
  logic              rd_active;
  logic              wr_active;
  logic [1:0]        byte_idx;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{fetch_addr[1:0], load_addr[1:0]};

  // Handshake: a requester holds req/addr/data stable until its ready is high;
  // the word is accepted in that same cycle, ready is high only in IDLE, and on
  // a tie the requester that did not win last time is granted.
  assign idle        = (state_q == IDLE);
  assign grant_fetch = fetch_req && (!load_req || (last_grant_q == GRANT_LOAD));
  assign grant_load  = load_req && (!fetch_req || (last_grant_q == GRANT_FETCH));
  assign fetch_ready = rst && idle && grant_fetch;
  assign load_ready  = rst && idle && grant_load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_ready) begin
          state_d = WR0;
        end else if (fetch_ready) begin
          state_d = RD0;
        end
      end
      RD0:     state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = RD3;
      RD3:     state_d = RDW;
      RDW:     state_d = DONE;
      WR0:     state_d = WR1;
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_active = 1'b0;
    wr_active = 1'b0;
    byte_idx  = 2'd0;
    case (state_q)
      RD0: begin rd_active = 1'b1; byte_idx = 2'd0; end
      RD1: begin rd_active = 1'b1; byte_idx = 2'd1; end
      RD2: begin rd_active = 1'b1; byte_idx = 2'd2; end
      RD3: begin rd_active = 1'b1; byte_idx = 2'd3; end
      WR0: begin wr_active = 1'b1; byte_idx = 2'd0; end
      WR1: begin wr_active = 1'b1; byte_idx = 2'd1; end
      WR2: begin wr_active = 1'b1; byte_idx = 2'd2; end
      WR3: begin wr_active = 1'b1; byte_idx = 2'd3; end
      default: begin
        rd_active = 1'b0;
        wr_active = 1'b0;
        byte_idx  = 2'd0;
      end
    endcase
  end

  // The aligned base keeps base+k inside the word, so the index is just appended.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (rd_active || wr_active) begin
      mem_addr = {base_q, byte_idx};
    end
    if (wr_active) begin
      mem_we = 1'b1;
      case (byte_idx)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_FETCH;
      base_q        <= '0;
      wdata_q       <= '0;
      op_rd_q       <= 1'b0;
      asm_q         <= '0;
      fetch_instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_ready) begin
        base_q       <= load_addr[ADDR_W-1:2];
        wdata_q      <= load_data;
        op_rd_q      <= 1'b0;
        last_grant_q <= GRANT_LOAD;
      end else if (fetch_ready) begin
        base_q       <= fetch_addr[ADDR_W-1:2];
        op_rd_q      <= 1'b1;
        last_grant_q <= GRANT_FETCH;
      end
      // Read data lags the address by one cycle, so byte 0 arrives during RD1.
      if ((state_q == RD1) || (state_q == RD2) || (state_q == RD3)) begin
        asm_q <= {asm_q[15:0], mem_rdata};
      end
      if (state_q == RDW) begin
        fetch_instr_q <= {asm_q, mem_rdata};
      end
    end
  end

  assign fetch_valid = (state_q == DONE) && op_rd_q;
  assign load_done   = (state_q == DONE) && !op_rd_q;
  assign fetch_instr = fetch_instr_q;
  assign busy        = !idle;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a byte-wide memory model behind the port.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        load_req;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [3:0]  dbg_state;

  logic [7:0]  mem_model [0:255];
  int          total_cnt;
  int          pass_cnt;

  imem_port_arbiter #(.ADDR_W(8), .MEM_BYTES(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data for an address appears the cycle after it is driven
  always @(posedge clk) begin
    mem_rdata <= mem_model[mem_addr];
    if (mem_we) mem_model[mem_addr] = mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] addr, input logic [7:0] exp_base,
                          input logic [31:0] exp_word, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    #1;
    total_cnt++;
    if ({fetch_ready, load_ready} !== 2'b10)
      $display("FAIL %s accept: ready f/l=%b want 10", tag, {fetch_ready, load_ready});
    else pass_cnt++;
    step();
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({mem_we, mem_addr, fetch_valid} !== {1'b0, exp_base + 8'(k), 1'b0})
        $display("FAIL %s rd%0d: we=%b addr=%h valid=%b want we=0 addr=%h valid=0",
                 tag, k, mem_we, mem_addr, fetch_valid, exp_base + 8'(k));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({fetch_valid, mem_we, mem_addr, busy} !== {1'b0, 1'b0, 8'h00, 1'b1})
      $display("FAIL %s rdw: valid=%b we=%b addr=%h busy=%b want 0 0 00 1",
               tag, fetch_valid, mem_we, mem_addr, busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({fetch_valid, fetch_instr} !== {1'b1, exp_word})
      $display("FAIL %s done: valid=%b instr=%h want 1 %h", tag, fetch_valid, fetch_instr, exp_word);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({fetch_valid, busy, fetch_instr} !== {1'b0, 1'b0, exp_word})
      $display("FAIL %s after: valid=%b busy=%b instr=%h want 0 0 %h",
               tag, fetch_valid, busy, fetch_instr, exp_word);
    else pass_cnt++;
  endtask

  task automatic do_load(input logic [7:0] addr, input logic [7:0] exp_base,
                         input logic [31:0] data, input string tag);
    logic [7:0] exp_byte;
    load_req  = 1'b1;
    load_addr = addr;
    load_data = data;
    #1;
    total_cnt++;
    if ({fetch_ready, load_ready} !== 2'b01)
      $display("FAIL %s accept: ready f/l=%b want 01", tag, {fetch_ready, load_ready});
    else pass_cnt++;
    step();
    load_req  = 1'b0;
    load_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      exp_byte = data[31 - 8*k -: 8];
      total_cnt++;
      if ({mem_we, mem_addr, mem_wdata, load_done} !== {1'b1, exp_base + 8'(k), exp_byte, 1'b0})
        $display("FAIL %s wr%0d: we=%b addr=%h wdata=%h done=%b want 1 %h %h 0",
                 tag, k, mem_we, mem_addr, mem_wdata, load_done, exp_base + 8'(k), exp_byte);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({load_done, mem_we, fetch_valid} !== 3'b100)
      $display("FAIL %s done: done=%b we=%b valid=%b want 1 0 0", tag, load_done, mem_we, fetch_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({load_done, busy} !== 2'b00)
      $display("FAIL %s after: done=%b busy=%b want 0 0", tag, load_done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_req = 1'b0; fetch_addr = 8'h00;
    load_req = 1'b0; load_addr = 8'h00; load_data = 32'h0;
    step();
    step();
    total_cnt++;
    if ({fetch_valid, load_done, mem_we, busy, fetch_ready, load_ready} !== 6'b0)
      $display("FAIL reset_flags: valid/done/we/busy/fr/lr=%b want 000000",
               {fetch_valid, load_done, mem_we, busy, fetch_ready, load_ready});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata} !== 16'h0000)
      $display("FAIL reset_mem: addr=%h wdata=%h want 00 00", mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({fetch_instr, dbg_state} !== 36'h0)
      $display("FAIL reset_state: instr=%h state=%0d want 0 0", fetch_instr, dbg_state);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    mem_model[4] = 8'hE3; mem_model[5] = 8'hA0; mem_model[6] = 8'h00; mem_model[7] = 8'h14;
    do_fetch(8'h04, 8'h04, 32'hE3A00014, "single_fetch");
    step();
  endtask

  task automatic test_load_readback();
    do_load(8'h08, 8'h08, 32'h12345678, "load8");
    step();
    total_cnt++;
    if ({mem_model[8], mem_model[9], mem_model[10], mem_model[11]} !== 32'h12345678)
      $display("FAIL load8_mem: got %h%h%h%h want 12345678",
               mem_model[8], mem_model[9], mem_model[10], mem_model[11]);
    else pass_cnt++;
    do_fetch(8'h08, 8'h08, 32'h12345678, "readback8");
    step();
  endtask

  task automatic test_alignment();
    do_fetch(8'h07, 8'h04, 32'hE3A00014, "align07");
    step();
    mem_model[252] = 8'hDE; mem_model[253] = 8'hAD; mem_model[254] = 8'hBE; mem_model[255] = 8'hEF;
    do_fetch(8'hFE, 8'hFC, 32'hDEADBEEF, "top_fe");
    step();
  endtask

  task automatic test_contention();
    logic       is_load [0:3];
    int         at_cyc  [0:3];
    int         n_grant;
    int         overlap;
    int         exp_cyc [0:3];
    logic       exp_load [0:3];
    logic       was_load;
    exp_cyc[0] = 0;  exp_cyc[1] = 6;  exp_cyc[2] = 13; exp_cyc[3] = 19;
    exp_load[0] = 1'b1; exp_load[1] = 1'b0; exp_load[2] = 1'b1; exp_load[3] = 1'b0;
    n_grant = 0;
    overlap = 0;
    rst = 1'b0;
    step();
    fetch_req = 1'b1; fetch_addr = 8'h04;
    load_req  = 1'b1; load_addr  = 8'h20; load_data = 32'hA1B2C3D4;
    step();
    rst = 1'b1;
    for (int cyc = 0; cyc < 40 && n_grant < 4; cyc++) begin
      #1;
      was_load = 1'b0;
      if (fetch_ready && load_ready) overlap++;
      if (load_ready || fetch_ready) begin
        is_load[n_grant] = load_ready;
        at_cyc[n_grant]  = cyc;
        was_load         = load_ready;
        n_grant++;
      end
      step();
      if (was_load) begin
        load_addr = load_addr + 8'h04;
        load_data = 32'h5E6F7A8B;
      end
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    total_cnt++;
    if (n_grant !== 4)
      $display("FAIL contention_count: grants=%0d want 4 within 40 cycles", n_grant);
    else pass_cnt++;
    total_cnt++;
    if (overlap !== 0)
      $display("FAIL contention_overlap: both-ready cycles=%0d want 0", overlap);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (i < n_grant) begin
        total_cnt++;
        if ({is_load[i], at_cyc[i]} !== {exp_load[i], exp_cyc[i]})
          $display("FAIL contention_grant%0d: load=%b cycle=%0d want load=%b cycle=%0d",
                   i, is_load[i], at_cyc[i], exp_load[i], exp_cyc[i]);
        else pass_cnt++;
      end
    end
    for (int w = 0; w < 12 && busy; w++) step();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL contention_drain: busy=%b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({mem_model[32], mem_model[33], mem_model[34], mem_model[35],
         mem_model[36], mem_model[37], mem_model[38], mem_model[39]} !== 64'hA1B2C3D4_5E6F7A8B)
      $display("FAIL contention_mem: got %h%h%h%h_%h%h%h%h want A1B2C3D4_5E6F7A8B",
               mem_model[32], mem_model[33], mem_model[34], mem_model[35],
               mem_model[36], mem_model[37], mem_model[38], mem_model[39]);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_write();
    int done_seen;
    done_seen = 0;
    mem_model[16] = 8'h11; mem_model[17] = 8'h22; mem_model[18] = 8'h33; mem_model[19] = 8'h44;
    load_req = 1'b1; load_addr = 8'h10; load_data = 32'hAABBCCDD;
    #1;
    total_cnt++;
    if (load_ready !== 1'b1)
      $display("FAIL midrst_accept: load_ready=%b want 1", load_ready);
    else pass_cnt++;
    step();
    load_req = 1'b0;
    step();
    step();
    total_cnt++;
    if ({mem_we, mem_addr} !== {1'b1, 8'h12})
      $display("FAIL midrst_wr2: we=%b addr=%h want 1 12", mem_we, mem_addr);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({mem_we, fetch_valid, load_done, busy, fetch_ready, load_ready, mem_addr, mem_wdata} !== 22'h0)
      $display("FAIL midrst_outputs: we/v/d/busy/fr/lr=%b addr=%h wdata=%h want all 0",
               {mem_we, fetch_valid, load_done, busy, fetch_ready, load_ready}, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({fetch_instr, dbg_state} !== 36'h0)
      $display("FAIL midrst_state: instr=%h state=%0d want 0 0", fetch_instr, dbg_state);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step();
      if (load_done) done_seen++;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (load_done) done_seen++;
      step();
    end
    total_cnt++;
    if (done_seen !== 0)
      $display("FAIL midrst_no_done: load_done cycles=%0d want 0", done_seen);
    else pass_cnt++;
    total_cnt++;
    if ({mem_model[16], mem_model[17], mem_model[18], mem_model[19]} !== 32'hAABB3344)
      $display("FAIL midrst_mem: got %h%h%h%h want AABB3344",
               mem_model[16], mem_model[17], mem_model[18], mem_model[19]);
    else pass_cnt++;
    total_cnt++;
    if ({dbg_state, busy} !== 5'b0)
      $display("FAIL midrst_idle: state=%0d busy=%b want 0 0", dbg_state, busy);
    else pass_cnt++;
    fetch_req = 1'b1; fetch_addr = 8'h04;
    load_req  = 1'b1; load_addr  = 8'h10; load_data = 32'h0;
    #1;
    total_cnt++;
    if ({fetch_ready, load_ready} !== 2'b01)
      $display("FAIL midrst_tie: ready f/l=%b want 01", {fetch_ready, load_ready});
    else pass_cnt++;
    fetch_req = 1'b0;
    load_req  = 1'b0;
    step();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL midrst_dropped: busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    for (int a = 0; a < 256; a++) mem_model[a] = 8'h00;
    test_reset();
    test_single_fetch();
    test_load_readback();
    test_alignment();
    test_contention();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Sequences and shares the single byte-wide port of the instruction memory between two requesters:
  - the IF-stage fetch (word read);
  - the program loader (word write).
- Converts each 32-bit word request into four byte accesses, big-endian: the byte at the base address is instr[31:24].
- Arbitrates round-robin on contention and returns assembled words to fetch.

Parameters:
- ADDR_W, 8, byte-address width of the instruction memory.
- MEM_BYTES, 256, memory size in bytes; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- fetch_req  input  1  fetch requests a word read.
- fetch_addr  input  ADDR_W  fetch byte address; bits [1:0] are ignored.
- fetch_ready  output  1  fetch request accepted this cycle.
- fetch_valid  output  1  one-cycle pulse: fetch_instr holds the completed word.
- fetch_instr  output  32  assembled instruction word.
- load_req  input  1  loader requests a word write.
- load_addr  input  ADDR_W  loader byte address; bits [1:0] are ignored.
- load_data  input  32  word to write.
- load_ready  output  1  loader request accepted this cycle.
- load_done  output  1  one-cycle pulse: write completed.
- mem_addr  output  ADDR_W  byte address to the memory.
- mem_we  output  1  byte write enable.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte. The byte for mem_addr driven in cycle n is valid in cycle n+1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States:
  - Read path: IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> RDW -> DONE -> IDLE.
  - Write path: IDLE -> WR0 -> WR1 -> WR2 -> WR3 -> DONE -> IDLE.
- Reset (rst low, asynchronous):
  - state = IDLE;
  - fetch_valid, load_done, mem_we, mem_addr, mem_wdata = 0;
  - fetch_instr = 0;
  - last_grant = FETCH.
  - Takes effect immediately, also mid-transaction. Bytes already written stay written; no done/valid pulse is issued for the aborted transaction.
- Arbitration (IDLE only):
  - Only one request active: grant it.
  - Both active: grant the requester that is not last_grant, so the loader wins the first tie after reset.
- fetch_ready / load_ready:
  - Combinational; high in IDLE only, for the granted requester only.
  - Never both high at once.
  - Acceptance cycle T = the cycle in which ready is high.
  - The requester must hold req, addr and data stable until ready.
- On acceptance:
  - Latch base = addr with [1:0] forced to 00.
  - Latch the loader's load_data.
  - Update last_grant.
- Read transaction (accepted in T):
  - T+1..T+4 (RD0..RD3): mem_addr = base+k, mem_we = 0.
  - Byte k is captured from mem_rdata at the end of cycles T+2..T+5 (RDW drains the last byte) into instr[31-8k -: 8].
  - T+6 (DONE): fetch_valid = 1 and fetch_instr is updated.
  - Latency from accept to valid: 6 cycles.
  - fetch_instr holds its value until the next read completes.
- Write transaction (accepted in T):
  - T+1..T+4 (WR0..WR3): mem_we = 1, mem_addr = base+k, mem_wdata = load_data[31-8k -: 8].
  - T+5 (DONE): load_done = 1.
- Outside active states: mem_we = 0, mem_addr = 0, mem_wdata = 0, and mem_rdata is ignored.
- DONE always returns to IDLE. Back-to-back accepts are therefore spaced at least 7 cycles for reads and 6 cycles for writes.
- Address arithmetic:
  - base+k never carries out of the aligned word, since k ≤ 3 and base is aligned.
  - Base 0xFC accesses 0xFC..0xFF; no wrap occurs.
- A request deasserted before ready is simply never served. A request raised while busy waits until IDLE.

Test Plan:
- Single fetch:
  - Stimulus: memory preloaded with E3 A0 00 14 at bytes 4..7; fetch_req with fetch_addr = 4 from IDLE.
  - Required: fetch_ready in T; mem_addr 4,5,6,7 in T+1..T+4 with mem_we = 0; fetch_valid only in T+6 with fetch_instr = 0xE3A00014.
- Loader write then read-back:
  - Stimulus: load_addr = 8, load_data = 0x12345678; then a fetch of address 8.
  - Required: writes 12@8, 34@9, 56@10, 78@11 in T+1..T+4; load_done in T+5; the subsequent fetch returns 0x12345678.
- Contention:
  - Stimulus: fetch_req and load_req both held high from reset release, loader supplying successive words.
  - Required: loader accepted first; fetch accepted 6 cycles later; grants alternate L, F, L, F on every tie; ready is never high for both.
- Alignment and top of memory:
  - Stimulus: fetch_addr = 0x07; then fetch_addr = 0xFE.
  - Required: the first fetch reads bytes 4..7; the second reads 0xFC..0xFF.
- Reset mid-write:
  - Stimulus: rst driven low during WR2 of a write of 0xAABBCCDD to address 16.
  - Required: all outputs are 0 immediately; bytes 16 and 17 are written, bytes 18 and 19 are unchanged; no load_done; after release, state is IDLE and a tie grants the loader.
